ioctl_loader_tx: RTL and testbench

IOCTL_LOADER_TX -- requirements
Module: ioctl_loader_tx

---
 rtl/ioctl_loader_tx.sv | 127 ++++++++++++
 tb/tb_ioctl_loader_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader_tx.sv
// Streams a byte source onto the ioctl download bus: PRE/POST framing around
// one write strobe per accepted byte, with WR_GAP idle cycles between strobes.
module ioctl_loader_tx #(
  parameter int unsigned WR_GAP = 1
) (
  input  logic        I_CLK,
  input  logic        I_RSTn,
  input  logic        I_START,
  input  logic [7:0]  I_INDEX,
  input  logic [24:0] I_LEN,
  input  logic        I_ABORT,
  input  logic [7:0]  I_BYTE,
  input  logic        I_BYTE_VALID,
  output logic        O_BYTE_READY,
  input  logic        I_IOCTL_WAIT,
  output logic        O_IOCTL_DOWNLOAD,
  output logic        O_IOCTL_WR,
  output logic [24:0] O_IOCTL_ADDR,
  output logic [7:0]  O_IOCTL_DOUT,
  output logic [7:0]  O_IOCTL_INDEX,
  output logic        O_BUSY,
  output logic        O_DONE
);

  typedef enum logic [2:0] {
    StIdle, StPre, StFetch, StWrite, StGap, StPost, StFin
  } state_e;

  localparam logic [3:0] GapLoad = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

  state_e      state_q;
  logic [24:0] len_q;
  logic [24:0] cnt_q;
  logic [3:0]  gap_q;
  logic        abort_q;
  logic        abort_now;
  logic        last_byte;

  assign abort_now = abort_q | I_ABORT;
  assign last_byte = ((cnt_q + 25'd1) == len_q);

  // Ready follows WAIT directly so a stalled sink can never have a byte handed over.
  assign O_BYTE_READY = (state_q == StFetch) & ~I_IOCTL_WAIT;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q          <= StIdle;
      len_q            <= '0;
      cnt_q            <= '0;
      gap_q            <= '0;
      abort_q          <= 1'b0;
      O_IOCTL_DOWNLOAD <= 1'b0;
      O_IOCTL_WR       <= 1'b0;
      O_IOCTL_ADDR     <= '0;
      O_IOCTL_DOUT     <= '0;
      O_IOCTL_INDEX    <= '0;
      O_BUSY           <= 1'b0;
      O_DONE           <= 1'b0;
    end else begin
      O_IOCTL_WR <= 1'b0;
      O_DONE     <= 1'b0;
      if (O_BUSY && I_ABORT) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (I_START) begin
            O_IOCTL_INDEX    <= I_INDEX;
            len_q            <= I_LEN;
            cnt_q            <= '0;
            O_IOCTL_ADDR     <= '0;
            abort_q          <= 1'b0;
            O_BUSY           <= 1'b1;
            O_IOCTL_DOWNLOAD <= 1'b1;
            state_q          <= StPre;
          end
        end
        StPre: begin
          state_q <= (len_q == '0) ? StPost : StFetch;
        end
        StFetch: begin
          if (abort_now) begin
            state_q <= StPost;
          end else if (I_BYTE_VALID && !I_IOCTL_WAIT) begin
            O_IOCTL_DOUT <= I_BYTE;
            O_IOCTL_ADDR <= cnt_q;
            O_IOCTL_WR   <= 1'b1;
            state_q      <= StWrite;
          end
        end
        StWrite: begin
          cnt_q <= cnt_q + 25'd1;
          if (last_byte || abort_now) begin
            state_q <= StPost;
          end else if (WR_GAP > 0) begin
            gap_q   <= GapLoad;
            state_q <= StGap;
          end else begin
            state_q <= StFetch;
          end
        end
        StGap: begin
          if (abort_now) begin
            state_q <= StPost;
          end else if (gap_q == '0) begin
            state_q <= StFetch;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        StPost: begin
          O_IOCTL_DOWNLOAD <= 1'b0;
          O_BUSY           <= 1'b0;
          O_DONE           <= 1'b1;
          state_q          <= StFin;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_loader_tx.sv
// Bench for ioctl_loader_tx: two instances (WR_GAP=1 and WR_GAP=0) driven from
// a transfer table plus random transfers, checked against a byte-stream model.
module tb_ioctl_loader_tx;

  typedef struct {
    int         dut;
    logic [7:0] idx;
    int         len;
    int         vmode;     // 0 valid always high, 1 toggling, 2 random
    bit         ramp;      // source bytes A0,A1,... instead of random
    bit         pre_abort; // pulse abort while idle before the start
    int         wait_at;   // hold WAIT after the write at this address
    int         wait_len;
    int         abort_at;  // pulse abort right after the write at this address
    int         mid_at;    // pulse START right after the write at this address
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start [2];
  logic        abort [2];
  logic        valid [2];
  logic        io_wait [2];
  logic        ready [2];
  logic        dl [2];
  logic        wr [2];
  logic        busy [2];
  logic        done [2];
  logic [7:0]  index [2];
  logic [7:0]  src_byte [2];
  logic [7:0]  dout [2];
  logic [7:0]  oidx [2];
  logic [24:0] len [2];
  logic [24:0] addr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ioctl_loader_tx #(.WR_GAP(g == 0 ? 1 : 0)) u_dut (
      .I_CLK           (clk),
      .I_RSTn          (rst_n),
      .I_START         (start[g]),
      .I_INDEX         (index[g]),
      .I_LEN           (len[g]),
      .I_ABORT         (abort[g]),
      .I_BYTE          (src_byte[g]),
      .I_BYTE_VALID    (valid[g]),
      .O_BYTE_READY    (ready[g]),
      .I_IOCTL_WAIT    (io_wait[g]),
      .O_IOCTL_DOWNLOAD(dl[g]),
      .O_IOCTL_WR      (wr[g]),
      .O_IOCTL_ADDR    (addr[g]),
      .O_IOCTL_DOUT    (dout[g]),
      .O_IOCTL_INDEX   (oidx[g]),
      .O_BUSY          (busy[g]),
      .O_DONE          (done[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wcnt [2], hs_cnt [2], fall_cnt [2], done_cnt [2], dl_cyc [2];
  int fall_cyc [2], last_wr_cyc [2], last_addr [2], ptr [2], vmode [2];
  bit wr_flag [2], hs_flag [2], dl_prev [2], wait_prev [2];
  logic [7:0] idx_exp [2];
  logic [7:0] srcmem [2][256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int dut);
    return (dut == 0) ? 1 : 0;
  endfunction

  // Model: the k-th accepted byte is written at address k; bytes stop after
  // len writes, or after the write that precedes an abort.
  function automatic int exp_writes(input xfer_t t);
    return (t.abort_at >= 0 && t.abort_at < t.len) ? t.abort_at + 1 : t.len;
  endfunction

  // Download window for an unstalled stream: PRE + (FETCH+WRITE) per byte
  // + gaps between bytes + POST.
  function automatic int exp_dl(input xfer_t t);
    if (t.wait_at >= 0 || t.abort_at >= 0 || t.vmode != 0) return -1;
    if (t.len == 0) return 2;
    return 2 + 2 * t.len + (t.len - 1) * gap_of(t.dut);
  endfunction

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        dl_prev[i] = 1'b0;
        wr_flag[i] = 1'b0;
        hs_flag[i] = 1'b0;
      end else begin
        hs_flag[i] = valid[i] & ready[i];
        if (hs_flag[i]) hs_cnt[i]++;
        if (io_wait[i]) check("ready_under_wait", 64'(ready[i]), 64'd0);
        wr_flag[i] = wr[i];
        if (wr[i]) begin
          last_addr[i] = int'(addr[i]);
          check("wr_addr", 64'(addr[i]), 64'(wcnt[i]));
          check("wr_dout", 64'(dout[i]), 64'(srcmem[i][wcnt[i] % 256]));
          check("wr_index", 64'(oidx[i]), 64'(idx_exp[i]));
          check("wr_download", 64'(dl[i]), 64'd1);
          check("wr_after_wait", 64'(wait_prev[i]), 64'd0);
          if (wcnt[i] > 0)
            check("wr_spacing", 64'((cyc - last_wr_cyc[i]) >= gap_of(i) + 2), 64'd1);
          last_wr_cyc[i] = cyc;
          wcnt[i]++;
        end
        if (dl[i]) dl_cyc[i]++;
        if (dl_prev[i] && !dl[i]) begin
          fall_cnt[i]++;
          fall_cyc[i] = cyc;
          check("done_at_fall", 64'(done[i]), 64'd1);
        end
        if (done[i]) begin
          done_cnt[i]++;
          check("done_busy", 64'(busy[i]), 64'd0);
        end
        dl_prev[i]   = dl[i];
        wait_prev[i] = io_wait[i];
      end
    end
  end

  // Byte source: advances only after a handshake, valid pattern per transfer.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs_flag[i]) begin
        ptr[i]++;
        src_byte[i] = srcmem[i][ptr[i] % 256];
      end
      case (vmode[i])
        0:       valid[i] = 1'b1;
        1:       valid[i] = ~valid[i];
        default: valid[i] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_stats(input xfer_t t);
    int i;
    i = t.dut;
    for (int k = 0; k < 256; k++) srcmem[i][k] = t.ramp ? 8'(8'hA0 + k) : 8'($urandom);
    wcnt[i] = 0; hs_cnt[i] = 0; fall_cnt[i] = 0; done_cnt[i] = 0; dl_cyc[i] = 0;
    fall_cyc[i] = 0; last_addr[i] = -1; ptr[i] = 0;
    src_byte[i] = srcmem[i][0];
    vmode[i] = t.vmode;
    idx_exp[i] = t.idx;
  endtask

  task automatic run(input xfer_t t, input bit pre_started);
    int i, budget, abort_cyc, wait_left, ew, ed;
    i = t.dut; abort_cyc = -1; wait_left = 0;
    ew = exp_writes(t); ed = exp_dl(t);
    if (!pre_started) begin
      clear_stats(t);
      if (t.pre_abort) begin
        abort[i] = 1'b1;
        @(posedge clk); #1;
        abort[i] = 1'b0;
      end
      index[i] = t.idx; len[i] = 25'(t.len); start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
    end
    index[i] = 8'($urandom); len[i] = 25'($urandom);
    budget = 4000;
    while (done_cnt[i] == 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      start[i] = 1'b0; abort[i] = 1'b0;
      if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) io_wait[i] = 1'b0;
      end
      if (wr_flag[i]) begin
        if (last_addr[i] == t.abort_at) begin abort[i] = 1'b1; abort_cyc = cyc + 1; end
        if (last_addr[i] == t.wait_at) begin io_wait[i] = 1'b1; wait_left = t.wait_len; end
        if (last_addr[i] == t.mid_at) begin start[i] = 1'b1; index[i] = ~t.idx; end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_timeout", 64'(budget > 0), 64'd1);
    check("write_count", 64'(wcnt[i]), 64'(ew));
    check("accept_count", 64'(hs_cnt[i]), 64'(ew));
    check("download_falls", 64'(fall_cnt[i]), 64'd1);
    check("done_pulses", 64'(done_cnt[i]), 64'd1);
    if (ed >= 0) check("download_cycles", 64'(dl_cyc[i]), 64'(ed));
    if (t.abort_at >= 0) check("abort_to_fall", 64'(fall_cyc[i] - abort_cyc), 64'd2);
    check("index_hold", 64'(oidx[i]), 64'(t.idx));
    check("busy_after", 64'(busy[i]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    xfer_t tab [7];
    xfer_t t;
    int budget;
    tab[0] = '{0, 8'h01,   4, 0, 1, 0, -1,  0, -1, -1};
    tab[1] = '{0, 8'h05,   0, 0, 0, 0, -1,  0, -1, -1};
    tab[2] = '{0, 8'h02,   3, 0, 0, 0,  0, 10, -1, -1};
    tab[3] = '{0, 8'h03, 100, 0, 0, 0, -1,  0,  5, -1};
    tab[4] = '{1, 8'h07,  12, 1, 0, 0, -1,  0, -1,  3};
    tab[5] = '{1, 8'h00,   6, 0, 0, 1, -1,  0, -1, -1};
    tab[6] = '{0, 8'h09,   1, 0, 1, 0, -1,  0, -1, -1};
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; abort[i] = 0; valid[i] = 0; io_wait[i] = 0;
      index[i] = 0; len[i] = 0; src_byte[i] = 0; vmode[i] = 0;
    end

    #2 rst_n = 1'b0;
    #20;
    for (int i = 0; i < 2; i++) begin
      check("rst_download", 64'(dl[i]), 64'd0);
      check("rst_wr", 64'(wr[i]), 64'd0);
      check("rst_addr", 64'(addr[i]), 64'd0);
      check("rst_dout", 64'(dout[i]), 64'd0);
      check("rst_index", 64'(oidx[i]), 64'd0);
      check("rst_ready", 64'(ready[i]), 64'd0);
      check("rst_busy", 64'(busy[i]), 64'd0);
      check("rst_done", 64'(done[i]), 64'd0);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 7; r++) run(tab[r], 1'b0);

    for (int r = 0; r < 12; r++) begin
      t = '{0, 8'h00, 0, 0, 0, 0, -1, 0, -1, -1};
      t.dut   = $urandom_range(0, 1);
      t.idx   = 8'($urandom);
      t.len   = $urandom_range(0, 20);
      t.vmode = $urandom_range(0, 2);
      if (t.len >= 2 && $urandom_range(0, 2) == 0) t.abort_at = $urandom_range(0, t.len - 2);
      run(t, 1'b0);
    end

    // Reset during a write, then restart straight out of reset.
    t = '{0, 8'h04, 8, 0, 0, 0, -1, 0, -1, -1};
    clear_stats(t);
    index[0] = t.idx; len[0] = 25'd8; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    budget = 200;
    do begin
      @(negedge clk); #2;
      budget--;
    end while (!wr[0] && budget > 0);
    check("rst_reach_write", 64'(wr[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_download", 64'(dl[0]), 64'd0);
    check("rst_mid_wr", 64'(wr[0]), 64'd0);
    check("rst_mid_addr", 64'(addr[0]), 64'd0);
    check("rst_mid_dout", 64'(dout[0]), 64'd0);
    check("rst_mid_index", 64'(oidx[0]), 64'd0);
    check("rst_mid_busy", 64'(busy[0]), 64'd0);
    check("rst_mid_index1", 64'(oidx[1]), 64'd0);
    @(posedge clk); #1;
    check("rst_mid_no_done", 64'(done[0]), 64'd0);
    check("rst_mid_done_count", 64'(done_cnt[0]), 64'd0);
    clear_stats(t);
    @(negedge clk); #2;
    index[0] = t.idx; len[0] = 25'd8; start[0] = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("start_after_rst_busy", 64'(busy[0]), 64'd1);
    check("start_after_rst_download", 64'(dl[0]), 64'd1);
    run(t, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
